serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial WIDTH-bit subtractor, the inverse operation of the adder chain.
//   - Computes diff = a - b - bin, one full-subtractor bit per clock, LSB first.
//   - Accepts operands over a valid/ready handshake.
//   - Returns diff plus the final borrow over a second valid/ready handshake.
//   - Intended as the small-area subtract path beside the parallel adders.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range WIDTH >= 1
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operands a, b, bin are valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      diff/bout/zero are valid (high only in DONE)
//   out_ready  in   1      consumer accepts the result
//   diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//   bout       out  1      final borrow; 1 when a < b + bin (unsigned)
//   zero       out  1      diff == 0
// BEHAVIOUR
//   Reset (async, immediate):
//   - state=IDLE, bit counter=0, borrow reg=0, diff=0, bout=0, zero=0, out_valid=0.
//   - in_ready=1 once rst deasserts.
//   FSM:
//   - IDLE:  in_ready=1. On an edge with in_valid=1, latch a, b and bin (bin goes
//            into the borrow reg), clear the counter, go to SHIFT.
//   - SHIFT: in_ready=0, out_valid=0. Each edge processes bit i = counter:
//            - d_i = a_i ^ b_i ^ br
//            - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
//            - d_i shifts into the result register at the MSB end, so after
//              WIDTH shifts d_0 sits at bit 0.
//            - counter increments.
//            After the WIDTH-th SHIFT edge: diff <= result, bout <= br',
//            zero <= (result == 0), go to DONE.
//   - DONE:  out_valid=1. diff, bout and zero are held stable.
//            On an edge with out_ready=1, go to IDLE.
//   Latency:
//   - Acceptance edge E0. out_valid rises after edge E(WIDTH), i.e. exactly WIDTH
//     cycles later.
//   - Throughput is one operation per WIDTH+2 cycles with out_ready tied high.
//   Handshake rules:
//   - in_valid is ignored outside IDLE; a, b and bin may change freely after E0.
//   - out_valid stays high until it is consumed; it never drops without
//     out_ready=1.
//   - No same-cycle re-accept: in_ready rises the cycle after the result handshake.
//   Outputs:
//   - diff, bout and zero are registered. They keep their last value in IDLE and
//     SHIFT and change only on the DONE-entry edge.
//   Arithmetic:
//   - Unsigned, modulo 2^WIDTH.
//   - The counter is $clog2(WIDTH+1) bits wide; WIDTH=1 completes in one SHIFT edge.
//   Boundary cases:
//   - a == b, bin=0 -> diff=0, bout=0, zero=1.
//   - a=0, b=0, bin=1 -> diff=all ones, bout=1.
//   - rst during SHIFT or DONE: abort, discard the result, no out_valid pulse.
//   - in_valid held high continuously: exactly one operation per IDLE visit.
// TESTING
//   1. WIDTH=8: a=0x35, b=0x12, bin=0 -> out_valid exactly 8 cycles after accept;
//      diff=0x23, bout=0, zero=0.
//   2. a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
//   3. a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0, zero=1; a=0xFF, b=0xFF, bin=0 -> zero=1.
//   4. Back-pressure: out_ready low for 5 cycles in DONE with in_valid high ->
//      diff/bout stable, in_ready=0, no new accept; in_ready=1 the cycle after
//      out_ready=1.
//   5. Assert rst for 1 cycle after 3 SHIFT edges -> all outputs return to reset
//      values immediately; out_valid stays 0; a new operation afterwards is correct.
//   6. WIDTH=4 and WIDTH=1: exhaustive a, b, bin, checked against reference model
//      {bout,diff} = {1'b0,a} - b - bin, with random out_ready stalls.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand and result handshakes for the bit-serial subtractor.
// Master drives operands and out_ready; slave (the subtractor) drives the result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one full-subtractor bit per clock, LSB first.
// state | meaning
// IDLE  | ready for operands; result registers hold the last answer
// SHIFT | one bit processed per edge, WIDTH edges total
// DONE  | result presented until the consumer takes it
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_subtractor_if.slave s_if
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_br;
    logic             r_bout;
    logic             r_zero;
    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_in_ready;
    logic             w_out_valid;

    assign w_accept   = (r_state == S_IDLE) && s_if.in_valid;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    // New bit enters at the MSB so that after WIDTH shifts bit 0 holds d_0.
    assign w_res_next = WIDTH'({w_d, r_res} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (s_if.in_valid)  w_next = S_SHIFT;
            S_SHIFT: if (w_last)         w_next = S_DONE;
            S_DONE:  if (s_if.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = ~rst;
            S_DONE:  w_out_valid = 1'b1;
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_res  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_a   <= s_if.a;
            r_b   <= s_if.b;
            r_br  <= s_if.bin;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_res <= w_res_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= w_br_next;
                r_zero <= (w_res_next == '0);
            end
        end
    end

    assign s_if.in_ready  = w_in_ready;
    assign s_if.out_valid = w_out_valid;
    assign s_if.diff      = r_diff;
    assign s_if.bout      = r_bout;
    assign s_if.zero      = r_zero;
endmodule
